// File: rtl/bcd_countdown_if.sv
// Bus bundle for the BCD countdown timer.
// master drives load/start/pause, slave returns the count.
interface bcd_countdown_if #(
    parameter int DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  start;
    logic                  pause;
    logic [4*DIGITS-1:0]   cont;
    logic                  running;
    logic                  done;
    logic                  zero;

    modport master (
        output load, load_val, start, pause,
        input  cont, running, done, zero
    );

    modport slave (
        input  load, load_val, start, pause,
        output cont, running, done, zero
    );
endinterface

// File: rtl/bcd_countdown.sv
// Multi-digit BCD down-counter with prescaler and zero flag.
// Define AUTO_RELOAD_EN to reload the preset on terminal decrement.
module bcd_countdown #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 1
) (
    input  logic          clk,
    input  logic          rst,
    bcd_countdown_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    cont_q, cont_d;
    logic [W-1:0]    rel_q, rel_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic            done_q, done_d;

    // Clamp every non-BCD digit to 9.
    function automatic logic [W-1:0] sanitise(
        input logic [W-1:0] v
    );
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Subtract one with a 0->9 borrow ripple.
    function automatic logic [W-1:0] bcd_dec(
        input logic [W-1:0] v
    );
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // State, count, reload and prescaler registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cont_q  <= '0;
            rel_q   <= '0;
            pre_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cont_q  <= cont_d;
            rel_q   <= rel_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
        end
    end

    // Next-state: load overrides everything, then per-state work.
    always_comb begin
        state_d = state_q;
        cont_d  = cont_q;
        rel_d   = rel_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
        if (bus.load) begin
            cont_d  = sanitise(bus.load_val);
            rel_d   = sanitise(bus.load_val);
            state_d = IDLE;
            pre_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && (cont_q != '0)) begin
                        state_d = RUN;
                        pre_d   = '0;
                    end
                end
                RUN: begin
                    if (!bus.pause) begin
                        if (pre_q == PMAX) begin
                            pre_d = '0;
                            if (cont_q == W'(1)) begin
                                done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                                cont_d = rel_q;
`else
                                cont_d  = '0;
                                state_d = DONE;
`endif
                            end else begin
                                cont_d = bcd_dec(cont_q);
                            end
                        end else begin
                            pre_d = pre_q + PW'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.cont    = cont_q;
    assign bus.running = (state_q == RUN);
    assign bus.done    = done_q;
    assign bus.zero    = (cont_q == '0);

endmodule
